// File: rtl/genbus_pkg.sv
// Shared types and widths for the generic bus arbiter.
// Address/data are byte-wide; the timeout counter covers the full 1..255 range.
package genbus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  // A single-master build still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/genbus_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1 (wrapping) for the
// first set request. No latency, no backpressure; 'any' is low when nothing is requested.
module genbus_rr_pick
  import genbus_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          any
);

  always_comb begin
    int k;
    k      = 0;
    winner = '0;
    any    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!any && req[IW'(k)]) begin
        any    = 1'b1;
        winner = IW'(k);
      end
    end
  end

endmodule

// File: rtl/genbus_arb.sv
// Round-robin arbiter granting one master at a time onto a shared byte bus.
// Request->b_vld in 1 cycle, b_rdy->m_done in 1 cycle; a stalled slave is aborted after TIMEOUT cycles.
module genbus_arb
  import genbus_pkg::*;
#(
  parameter int NMASTERS = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NMASTERS-1:0]              m_req,
  input  logic [NMASTERS-1:0][ADDR_W-1:0]  m_adr,
  input  logic [NMASTERS-1:0]              m_we,
  input  logic [NMASTERS-1:0][DATA_W-1:0]  m_wdat,
  output logic [NMASTERS-1:0]              m_gnt,
  output logic [NMASTERS-1:0]              m_done,
  output logic                             m_err,
  output logic [DATA_W-1:0]                m_rdat,
  output logic                             b_vld,
  output logic [ADDR_W-1:0]                b_adr,
  output logic                             b_we,
  output logic [DATA_W-1:0]                b_wdat,
  input  logic                             b_rdy,
  input  logic [DATA_W-1:0]                b_rdat
);

  localparam int IW = idx_w(NMASTERS);

  state_e              state_q, state_d;
  logic [IW-1:0]       win_q, win_d;
  logic [IW-1:0]       last_q, last_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic [TCNT_W-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]       pick_win;
  logic                pick_any;

  genbus_rr_pick #(
    .N  (NMASTERS),
    .IW (IW)
  ) u_pick (
    .req    (m_req),
    .last   (last_q),
    .winner (pick_win),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;

    m_gnt   = '0;
    m_done  = '0;
    m_err   = 1'b0;
    m_rdat  = '0;
    b_vld   = 1'b0;
    b_adr   = '0;
    b_we    = 1'b0;
    b_wdat  = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          win_d   = pick_win;
          adr_d   = m_adr[pick_win];
          we_d    = m_we[pick_win];
          wdat_d  = m_wdat[pick_win];
          state_d = XFER;
        end
      end

      XFER: begin
        m_gnt[win_q] = 1'b1;
        b_vld        = 1'b1;
        b_adr        = adr_q;
        b_we         = we_q;
        b_wdat       = wdat_q;
        // A slave answering on the last allowed cycle still completes normally.
        if (b_rdy) begin
          rdat_d  = we_q ? '0 : b_rdat;
          state_d = DONE;
        end else if (cnt_q == TCNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        m_gnt[win_q]  = 1'b1;
        m_done[win_q] = 1'b1;
        m_rdat        = rdat_q;
        last_d        = win_q;
        state_d       = IDLE;
      end

      ERR: begin
        m_gnt[win_q]  = 1'b1;
        m_done[win_q] = 1'b1;
        m_err         = 1'b1;
        last_d        = win_q;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // last_q resets to the top index so master 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(NMASTERS - 1);
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
